// File: rtl/hilo_div_seq.sv
// hilo_div_seq: multi-cycle DIV/DIVU sequencer that owns the HI/LO write port.
// A radix-2 restoring divider produces one quotient bit per cycle on operand
// magnitudes. A fix-up state then re-applies the signs. LO receives the
// quotient and HI receives the remainder. Any ID instruction that touches
// HI/LO is stalled until the result has been written.
// CNT_W must satisfy 2**CNT_W >= WIDTH so the iteration counter can reach WIDTH-1.
module hilo_div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_div,
    input  logic             div_sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             hilo_req,
    output logic             busy,
    output logic             hilo_stall,
    output logic             done,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_ZERO,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Partial remainder is one bit wider than the operands so the shifted
    // value never overflows before the trial subtraction.
    logic [WIDTH:0]   prem_q, prem_d;
    // Quotient shift register. It starts as the dividend magnitude and is
    // consumed MSB-first while quotient bits enter at the LSB. On the
    // divide-by-zero path it instead carries the raw dividend to the ZERO state.
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             quot_neg_q, quot_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH+1:0] trial;

    // Operand magnitudes: negate only signed operands with the MSB set.
    // The most negative value maps onto the unsigned magnitude 2**(WIDTH-1).
    assign dvd_mag = (div_sign && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    assign dvs_mag = (div_sign && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

    // Trial subtraction of the shifted {prem, q} pair. Two extra bits keep the
    // sign bit meaningful for every possible partial remainder.
    assign trial = {prem_q, q_q[WIDTH-1]} - {2'b00, dvsr_q};

    // State and datapath registers; reset discards any in-flight divide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            prem_q     <= '0;
            q_q        <= '0;
            dvsr_q     <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prem_q     <= prem_d;
            q_q        <= q_d;
            dvsr_q     <= dvsr_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
        end
    end

    // Next-state logic and the divide iteration; everything holds unless changed.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prem_d     = prem_q;
        q_d        = q_q;
        dvsr_d     = dvsr_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start_div) begin
                    quot_neg_d = div_sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rem_neg_d  = div_sign & dividend[WIDTH-1];
                    cnt_d      = '0;
                    prem_d     = '0;
                    dvsr_d     = dvs_mag;
                    if (divisor == '0) begin
                        q_d     = dividend;
                        state_d = S_ZERO;
                    end else begin
                        q_d     = dvd_mag;
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (!trial[WIDTH+1]) begin
                    prem_d = trial[WIDTH:0];
                    q_d    = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    prem_d = {prem_q[WIDTH-1:0], q_q[WIDTH-1]};
                    q_d    = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                quot_d  = quot_neg_q ? (~q_q + 1'b1) : q_q;
                rem_d   = rem_neg_q ? (~prem_q[WIDTH-1:0] + 1'b1) : prem_q[WIDTH-1:0];
                dbz_d   = 1'b0;
                state_d = S_DONE;
            end

            S_ZERO: begin
                quot_d  = '1;
                rem_d   = q_q;
                dbz_d   = 1'b1;
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign hi_we       = done;
    assign lo_we       = done;
    assign hilo_stall  = hilo_req & (busy | start_div);
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_div_seq.sv
// Directed testbench for hilo_div_seq with hand-computed expected results.
module tb_hilo_div_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start_div;
    logic         div_sign;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         hilo_req;
    logic         busy;
    logic         hilo_stall;
    logic         done;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         div_by_zero;

    int total;
    int bad;

    hilo_div_seq #(.WIDTH(W), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_div  (start_div),
        .div_sign   (div_sign),
        .dividend   (dividend),
        .divisor    (divisor),
        .hilo_req   (hilo_req),
        .busy       (busy),
        .hilo_stall (hilo_stall),
        .done       (done),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .quot       (quot),
        .rem        (rem),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        start_div = 1'b1;
        div_sign  = sgn;
        dividend  = a;
        divisor   = b;
    endtask

    task automatic runDivide(input string tag, input logic sgn,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                             input logic exp_dbz, input int exp_lat,
                             input logic req, input int ignore_at);
        int           done_cnt;
        int           done_cyc;
        int           busy_err;
        int           we_err;
        int           stall_err;
        logic [W-1:0] got_q;
        logic [W-1:0] got_r;
        logic         got_dbz;
        done_cnt  = 0;
        done_cyc  = -1;
        busy_err  = 0;
        we_err    = 0;
        stall_err = 0;
        got_q     = '0;
        got_r     = '0;
        got_dbz   = 1'b0;
        hilo_req  = req;
        applyStimulus(sgn, a, b);
        #1;
        if (req) checkOutput({tag, "_stall_c0"}, W'(hilo_stall), W'(1));
        tick;
        start_div = 1'b0;
        for (int c = 1; c <= exp_lat + 1; c++) begin
            if (busy !== (c <= exp_lat)) busy_err++;
            if (hi_we !== done || lo_we !== done) we_err++;
            if (req && (hilo_stall !== (c <= exp_lat))) stall_err++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
                got_q    = quot;
                got_r    = rem;
                got_dbz  = div_by_zero;
            end
            if (c == ignore_at) begin
                applyStimulus(1'b1, 32'd9, 32'd0);
            end
            tick;
            start_div = 1'b0;
        end
        checkOutput({tag, "_done_pulses"}, W'(done_cnt), W'(1));
        checkOutput({tag, "_done_cycle"}, W'(done_cyc), W'(exp_lat));
        checkOutput({tag, "_quot"}, got_q, exp_q);
        checkOutput({tag, "_rem"}, got_r, exp_r);
        checkOutput({tag, "_dbz"}, W'(got_dbz), W'(exp_dbz));
        checkOutput({tag, "_busy_window_errs"}, W'(busy_err), W'(0));
        checkOutput({tag, "_we_errs"}, W'(we_err), W'(0));
        if (req) checkOutput({tag, "_stall_window_errs"}, W'(stall_err), W'(0));
        checkOutput({tag, "_quot_hold"}, quot, exp_q);
        checkOutput({tag, "_rem_hold"}, rem, exp_r);
        hilo_req = 1'b0;
    endtask

    task automatic resetMidDivide;
        int done_cnt;
        done_cnt = 0;
        applyStimulus(1'b0, 32'd50, 32'd5);
        tick;
        start_div = 1'b0;
        repeat (9) tick;
        checkOutput("rst_busy_before", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", W'(busy), W'(0));
        checkOutput("rst_done", W'(done), W'(0));
        checkOutput("rst_we", W'({hi_we, lo_we}), W'(0));
        checkOutput("rst_quot", quot, 32'h0);
        checkOutput("rst_rem", rem, 32'h0);
        checkOutput("rst_dbz", W'(div_by_zero), W'(0));
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) done_cnt++;
            if (c == 2) rst_n = 1'b1;
            tick;
        end
        checkOutput("rst_no_done", W'(done_cnt), W'(0));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        start_div = 1'b0;
        div_sign  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        hilo_req  = 1'b0;
        tick;
        tick;
        checkOutput("reset_busy", W'(busy), W'(0));
        checkOutput("reset_done", W'(done), W'(0));
        checkOutput("reset_quot", quot, 32'h0);
        checkOutput("reset_rem", rem, 32'h0);
        checkOutput("reset_dbz", W'(div_by_zero), W'(0));
        rst_n = 1'b1;
        tick;

        runDivide("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 1'b0, -1);
        runDivide("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 1'b0, -1);
        runDivide("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 34, 1'b0, -1);
        runDivide("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 34, 1'b0, -1);
        runDivide("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 34, 1'b0, -1);
        runDivide("stall_ign", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 34, 1'b1, 5);
        runDivide("div_zero", 1'b0, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 2, 1'b0, -1);
        resetMidDivide();
        runDivide("after_rst", 1'b0, 32'd12345, 32'd100, 32'd123, 32'd45, 1'b0, 34, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
